// File: rtl/coproc_sequencer.sv
// Command sequencer for the 5x5 int8 matrix ALU. It holds the operand, scalar and size registers,
// runs one ALU operation per EXEC instruction and returns exactly one response per instruction.
module coproc_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int DET_TIMEOUT   = 64
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [19:0]  instr,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [7:0]   rsp_data,
    output logic         rsp_ovf,
    output logic         rsp_err,
    output logic         busy,
    output logic [199:0] alu_a_flat,
    output logic [199:0] alu_b_flat,
    output logic [7:0]   alu_scalar,
    output logic [2:0]   alu_matrix_size,
    output logic [2:0]   alu_opcode,
    input  logic [199:0] alu_c_flat,
    input  logic [7:0]   alu_number,
    input  logic         alu_overflow,
    input  logic         alu_done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] CLS_LOAD   = 2'b00;
    localparam logic [1:0] CLS_CONFIG = 2'b01;
    localparam logic [1:0] CLS_EXEC   = 2'b10;
    localparam logic [1:0] CLS_READ   = 2'b11;

    localparam logic [2:0] OP_DET = 3'b111;

    localparam int CW = $clog2(SETTLE_CYCLES + DET_TIMEOUT + 2);
    // cnt holds (edges since accept - 1), so these are the edge numbers shifted down by one.
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_CNT   = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(DET_TIMEOUT - 2);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    op_reg;
    logic [199:0]  c_reg;
    logic [7:0]    num_reg;
    logic          ovf_reg;

    logic [1:0] f_cls;
    logic       f_sel;
    logic [4:0] f_idx;
    logic [7:0] f_data;
    logic [7:0] idx_base;
    logic       idx_ok;

    assign f_cls    = instr[19:18];
    assign f_sel    = instr[17];
    assign f_idx    = instr[16:12];
    assign f_data   = instr[7:0];
    assign idx_base = {f_idx, 3'b000};
    assign idx_ok   = (f_idx <= 5'd24);

    assign instr_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign rsp_valid   = (state == ST_RESP);
    assign alu_opcode  = (state == ST_EXEC) ? op_reg : 3'b000;

    // NOTE: every state register uses non-blocking assignment and sits under the async reset,
    // so a reset mid-operation drops straight back to IDLE without emitting a response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            op_reg          <= 3'b000;
            alu_a_flat      <= '0;
            alu_b_flat      <= '0;
            c_reg           <= '0;
            alu_scalar      <= 8'h00;
            alu_matrix_size <= 3'd5;
            num_reg         <= 8'h00;
            ovf_reg         <= 1'b0;
            rsp_data        <= 8'h00;
            rsp_ovf         <= 1'b0;
            rsp_err         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        rsp_data <= 8'h00;
                        rsp_ovf  <= 1'b0;
                        rsp_err  <= 1'b0;
                        state    <= ST_RESP;
                        case (f_cls)
                            CLS_LOAD: begin
                                if (!idx_ok)     rsp_err <= 1'b1;
                                else if (f_sel)  alu_b_flat[idx_base +: 8] <= f_data;
                                else             alu_a_flat[idx_base +: 8] <= f_data;
                            end
                            CLS_CONFIG: begin
                                if (f_sel)
                                    alu_scalar <= f_data;
                                else if (f_data[2:0] >= 3'd2 && f_data[2:0] <= 3'd5)
                                    alu_matrix_size <= f_data[2:0];
                                else
                                    rsp_err <= 1'b1;
                            end
                            CLS_EXEC: begin
                                if (f_data[2:0] == 3'b000) begin
                                    rsp_err <= 1'b1;
                                end else begin
                                    op_reg <= f_data[2:0];
                                    cnt    <= '0;
                                    state  <= ST_EXEC;
                                end
                            end
                            CLS_READ: begin
                                rsp_ovf <= ovf_reg;
                                if (f_sel)       rsp_data <= num_reg;
                                else if (idx_ok) rsp_data <= c_reg[idx_base +: 8];
                                else             rsp_err  <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_EXEC: begin
                    cnt <= cnt + 1'b1;
                    if (op_reg != OP_DET) begin
                        if (cnt == SETTLE_LAST) begin
                            c_reg   <= alu_c_flat;
                            ovf_reg <= alu_overflow;
                            rsp_ovf <= alu_overflow;
                            state   <= ST_RESP;
                        end
                    end else if (alu_done && cnt >= SETTLE_CNT) begin
                        num_reg  <= alu_number;
                        ovf_reg  <= alu_overflow;
                        rsp_data <= alu_number;
                        rsp_ovf  <= alu_overflow;
                        state    <= ST_RESP;
                    end else if (cnt == TIMEOUT_LAST) begin
                        rsp_err <= 1'b1;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coproc_sequencer.sv
// Self-checking bench for coproc_sequencer: a small ALU model drives the datapath inputs and an
// instruction-level model predicts every response, its latency and the operand register contents.
module tb_coproc_sequencer;

    localparam int S  = 1;
    localparam int DT = 64;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         instr_valid;
    logic         instr_ready;
    logic [19:0]  instr;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [7:0]   rsp_data;
    logic         rsp_ovf;
    logic         rsp_err;
    logic         busy;
    logic [199:0] alu_a_flat;
    logic [199:0] alu_b_flat;
    logic [7:0]   alu_scalar;
    logic [2:0]   alu_matrix_size;
    logic [2:0]   alu_opcode;
    logic [199:0] alu_c_flat;
    logic [7:0]   alu_number;
    logic         alu_overflow;
    logic         alu_done;

    coproc_sequencer #(.SETTLE_CYCLES(S), .DET_TIMEOUT(DT)) dut (
        .clock(clock), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_ovf(rsp_ovf), .rsp_err(rsp_err), .busy(busy),
        .alu_a_flat(alu_a_flat), .alu_b_flat(alu_b_flat), .alu_scalar(alu_scalar),
        .alu_matrix_size(alu_matrix_size), .alu_opcode(alu_opcode),
        .alu_c_flat(alu_c_flat), .alu_number(alu_number),
        .alu_overflow(alu_overflow), .alu_done(alu_done)
    );

    always #5 clock = ~clock;

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    // ---------------- ALU model ----------------
    int   hold_cnt = 0;
    int   det_delay = 5;
    logic det_en = 1'b1;

    function automatic logic [7:0] elem(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic elem_ovf(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = elem(op, a, b);
        case (op)
            3'd1:    return (a[7] == b[7]) && (r[7] != a[7]);
            3'd2:    return (a[7] != b[7]) && (r[7] != a[7]);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] det2(input logic [7:0] a0, input logic [7:0] a1,
                                        input logic [7:0] a5, input logic [7:0] a6);
        int d;
        d = $signed(a0) * $signed(a6) - $signed(a1) * $signed(a5);
        return d[7:0];
    endfunction

    always @(posedge clock) hold_cnt <= (alu_opcode == 3'd7) ? hold_cnt + 1 : 0;

    always_comb begin
        alu_c_flat   = '0;
        alu_overflow = 1'b0;
        for (int i = 0; i < 25; i++) begin
            alu_c_flat[i*8 +: 8] = elem(alu_opcode, alu_a_flat[i*8 +: 8], alu_b_flat[i*8 +: 8]);
            if (alu_opcode != 3'd7 && elem_ovf(alu_opcode, alu_a_flat[i*8 +: 8], alu_b_flat[i*8 +: 8]))
                alu_overflow = 1'b1;
        end
        alu_number = det2(alu_a_flat[7:0], alu_a_flat[15:8], alu_a_flat[47:40], alu_a_flat[55:48]);
        alu_done   = det_en && (alu_opcode == 3'd7) && (hold_cnt >= det_delay);
    end

    // ---------------- instruction-level model ----------------
    logic [7:0] ma [25];
    logic [7:0] mb [25];
    logic [7:0] mc [25];
    logic [7:0] mnum, mscalar;
    logic [2:0] msize;
    logic       movf;
    logic       mon_en = 1'b0;
    logic [7:0] last_data;

    task automatic model_reset();
        for (int i = 0; i < 25; i++) begin ma[i] = 8'h00; mb[i] = 8'h00; mc[i] = 8'h00; end
        mnum = 8'h00; mscalar = 8'h00; msize = 3'd5; movf = 1'b0;
    endtask

    function automatic logic [199:0] pack(input logic [7:0] m [25]);
        logic [199:0] v;
        for (int i = 0; i < 25; i++) v[i*8 +: 8] = m[i];
        return v;
    endfunction

    task automatic model_step(input logic [1:0] cls, input logic sel, input logic [4:0] idx,
                              input logic [7:0] data, output logic [7:0] e_data, output logic e_err,
                              output logic e_ovf, output logic chk_ovf, output int e_lat);
        logic [2:0] op;
        e_data = 8'h00; e_err = 1'b0; e_ovf = 1'b0; chk_ovf = 1'b0; e_lat = 1;
        op = data[2:0];
        case (cls)
            2'b00: if (idx > 24) e_err = 1'b1; else if (sel) mb[idx] = data; else ma[idx] = data;
            2'b01: begin
                if (sel) mscalar = data;
                else if (op >= 2 && op <= 5) msize = op;
                else e_err = 1'b1;
            end
            2'b10: begin
                if (op == 3'd0) begin
                    e_err = 1'b1;
                end else if (op != 3'd7) begin
                    movf = 1'b0;
                    for (int i = 0; i < 25; i++) begin
                        mc[i] = elem(op, ma[i], mb[i]);
                        movf  = movf | elem_ovf(op, ma[i], mb[i]);
                    end
                    e_ovf = movf; chk_ovf = 1'b1; e_lat = S + 1;
                end else if (det_en) begin
                    mnum = det2(ma[0], ma[1], ma[5], ma[6]);
                    movf = 1'b0;
                    e_data = mnum; e_ovf = 1'b0; chk_ovf = 1'b1;
                    e_lat = ((det_delay + 1 > S + 1) ? det_delay + 1 : S + 1) + 1;
                end else begin
                    e_err = 1'b1; e_lat = DT;
                end
            end
            default: begin
                e_ovf = movf; chk_ovf = 1'b1;
                if (sel) e_data = mnum;
                else if (idx > 24) e_err = 1'b1;
                else e_data = mc[idx];
            end
        endcase
    endtask

    // Continuous comparison of the register-file outputs against the model.
    always @(negedge clock) begin
        if (mon_en) begin
            check("a_regs", alu_a_flat, pack(ma));
            check("b_regs", alu_b_flat, pack(mb));
            check("scalar", alu_scalar, mscalar);
            check("size", alu_matrix_size, msize);
            if (!busy || rsp_valid) check("opcode_outside_exec", alu_opcode, 3'd0);
        end
    end

    task automatic run_instr(input logic [1:0] cls, input logic sel, input logic [4:0] idx,
                             input logic [7:0] data, input int hold);
        logic [7:0] e_data;
        logic       e_err, e_ovf, chk_ovf;
        int         e_lat, lat, w;
        @(negedge clock);
        instr       = {cls, sel, idx, 4'b0000, data};
        instr_valid = 1'b1;
        w = 0;
        while (!instr_ready && w < 100) begin @(negedge clock); w++; end
        if (!instr_ready) begin
            check("accept_timeout", 1'b0, 1'b1);
            instr_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1 instr_valid = 1'b0;
        model_step(cls, sel, idx, data, e_data, e_err, e_ovf, chk_ovf, e_lat);
        lat = 0;
        do begin @(negedge clock); lat++; end while (!rsp_valid && lat < DT + 20);
        check("rsp_latency", lat, e_lat);
        check("rsp_valid", rsp_valid, 1'b1);
        check("rsp_data", rsp_data, e_data);
        check("rsp_err", rsp_err, e_err);
        if (chk_ovf) check("rsp_ovf", rsp_ovf, e_ovf);
        last_data = rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_data", rsp_data, e_data);
            check("bp_err", rsp_err, e_err);
            check("bp_instr_ready", instr_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        check("post_hs_valid", rsp_valid, 1'b0);
        check("post_hs_ready", instr_ready, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; instr_valid = 1'b0; instr = '0; rsp_ready = 1'b0;
        model_reset();
        #12;
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_instr_ready", instr_ready, 1'b1);
        check("rst_opcode", alu_opcode, 3'd0);
        check("rst_size", alu_matrix_size, 3'd5);
        check("rst_a", alu_a_flat, 200'd0);
        check("rst_rsp_fields", {rsp_data, rsp_err, rsp_ovf}, 10'd0);
        #11 reset_n = 1'b1;
        mon_en = 1'b1;

        // Loads are visible on the flat bus; C is still zero before any EXEC.
        run_instr(2'b00, 1'b0, 5'd0, 8'hE4, 0);
        run_instr(2'b00, 1'b0, 5'd24, 8'h01, 0);
        run_instr(2'b11, 1'b0, 5'd0, 8'h00, 0);
        check("read_before_exec_literal", last_data, 8'h00);
        check("a0_literal", alu_a_flat[7:0], 8'hE4);
        check("a24_literal", alu_a_flat[199:192], 8'h01);

        for (int i = 0; i < 25; i++) begin
            run_instr(2'b00, 1'b0, 5'(i), 8'h01, 0);
            run_instr(2'b00, 1'b1, 5'(i), 8'h02, 0);
        end
        run_instr(2'b10, 1'b0, 5'd0, 8'd1, 0);
        run_instr(2'b11, 1'b0, 5'd12, 8'h00, 0);
        check("c12_literal", last_data, 8'h03);

        // Signed overflow on one element, then a rejected EXEC must leave results intact.
        run_instr(2'b00, 1'b0, 5'd3, 8'h7F, 0);
        run_instr(2'b00, 1'b1, 5'd3, 8'h01, 0);
        run_instr(2'b10, 1'b0, 5'd0, 8'd1, 0);
        run_instr(2'b10, 1'b0, 5'd0, 8'd2, 0);
        run_instr(2'b10, 1'b0, 5'd0, 8'd1, 0);
        run_instr(2'b10, 1'b0, 5'd0, 8'd0, 0);
        run_instr(2'b11, 1'b0, 5'd3, 8'h00, 0);
        check("c3_literal", last_data, 8'h80);

        run_instr(2'b00, 1'b0, 5'd25, 8'h55, 0);
        run_instr(2'b01, 1'b0, 5'd0, 8'd6, 0);
        check("size_unchanged_literal", alu_matrix_size, 3'd5);
        run_instr(2'b01, 1'b0, 5'd0, 8'd1, 0);
        run_instr(2'b01, 1'b1, 5'd0, 8'h5A, 0);

        // 2x2 determinant [1 2; 3 4] = -2.
        run_instr(2'b01, 1'b0, 5'd0, 8'd2, 0);
        run_instr(2'b00, 1'b0, 5'd0, 8'd1, 0);
        run_instr(2'b00, 1'b0, 5'd1, 8'd2, 0);
        run_instr(2'b00, 1'b0, 5'd5, 8'd3, 0);
        run_instr(2'b00, 1'b0, 5'd6, 8'd4, 0);
        run_instr(2'b10, 1'b0, 5'd0, 8'd7, 0);
        check("det_literal", last_data, 8'hFE);
        run_instr(2'b11, 1'b1, 5'd0, 8'h00, 0);
        check("num_read_literal", last_data, 8'hFE);

        det_en = 1'b0;
        run_instr(2'b10, 1'b0, 5'd0, 8'd7, 0);
        check("timeout_opcode_idle", alu_opcode, 3'd0);
        run_instr(2'b11, 1'b1, 5'd0, 8'h00, 10);
        run_instr(2'b11, 1'b0, 5'd30, 8'h00, 0);

        // Reset in the middle of a determinant wait.
        @(negedge clock);
        instr = {2'b10, 1'b0, 5'd0, 4'b0000, 8'd7};
        instr_valid = 1'b1;
        @(posedge clock);
        #1 instr_valid = 1'b0;
        check("exec_busy", busy, 1'b1);
        check("exec_opcode", alu_opcode, 3'd7);
        repeat (3) @(negedge clock);
        #3 reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_opcode", alu_opcode, 3'd0);
        check("midrst_size", alu_matrix_size, 3'd5);
        check("midrst_a", alu_a_flat, 200'd0);
        @(negedge clock);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("no_rsp_after_reset", rsp_valid, 1'b0);
        end
        det_en = 1'b1;
        run_instr(2'b11, 1'b1, 5'd0, 8'h00, 0);
        run_instr(2'b11, 1'b0, 5'd12, 8'h00, 0);

        mon_en = 1'b0;
        @(negedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/coproc_sequencer.md
Name: coproc_sequencer

Overview:
- Command-level controller that owns the alu matrix datapath: operand registers A/B (5x5 int8, 200-bit flat), scalar, matrix_size and opcode.
- Accepts instructions over a valid/ready stream: element load, config, execute, result read.
- Sequences each ALU operation: combinational ops use a fixed settle count; determinant (opcode 111) waits for alu_done, with a timeout.
- Returns exactly one response per instruction over a valid/ready stream. Sits between the host/bus interface and the alu.

Parameters:
SETTLE_CYCLES, 1, cycles opcode is held before capturing results of opcodes 001-110 (min 1)
DET_TIMEOUT, 64, max cycles waiting for alu_done on opcode 111 before error

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction present
instr_ready  output  1  sequencer can accept instruction
instr  input  20  [19:18] class (00 LOAD, 01 CONFIG, 10 EXEC, 11 READ); [17] sel; [16:12] index; [11:8] reserved; [7:0] data
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  8  read data / determinant
rsp_ovf  output  1  overflow captured by last EXEC (EXEC and READ responses)
rsp_err  output  1  instruction rejected or timed out
busy  output  1  state != IDLE
alu_a_flat, alu_b_flat  output  200  operand registers; element i at [i*8 +: 8], i = row*5+col
alu_scalar  output  8  scalar register
alu_matrix_size  output  3  size register (2..5)
alu_opcode  output  3  000 except in EXEC
alu_c_flat  input  200  ALU matrix result
alu_number  input  8  ALU determinant result (signed)
alu_overflow  input  1  ALU overflow flag
alu_done  input  1  ALU determinant complete

Behaviour:
- Reset (async, reset_n=0): state IDLE. A, B, C_reg, scalar, num_reg, ovf_reg = 0; size = 5; alu_opcode = 000; rsp_valid, rsp_data, rsp_ovf, rsp_err = 0; busy = 0. Reset mid-EXEC or mid-RESP aborts with no response.
- instr_ready = 1 only in IDLE; accept on instr_valid & instr_ready at rising edge T0.
- States: IDLE, EXEC, RESP.
- IDLE -> RESP at T0 for LOAD, CONFIG, READ, and for any rejected instruction. A valid EXEC goes to EXEC.
- LOAD: sel 0 writes A[index] = data; sel 1 writes B[index] = data. index > 24 -> rsp_err=1, no write.
- CONFIG: sel 0 sets size = data[2:0]. A value outside 2..5 -> rsp_err=1, size unchanged. sel 1 sets scalar = data.
- READ: sel 0 gives rsp_data = C_reg[index] (index > 24 -> err, data 0). sel 1 gives rsp_data = num_reg. rsp_ovf = ovf_reg.
- EXEC: opcode = data[2:0]; 000 -> rsp_err. From T0, alu_opcode is driven with the opcode while in EXEC; a counter is cleared at T0.
- EXEC, opcode 001-110: at edge T0+SETTLE_CYCLES, capture C_reg = alu_c_flat and ovf_reg = alu_overflow, then go to RESP. rsp_data = 0.
- EXEC, opcode 111: alu_done is ignored for the first SETTLE_CYCLES cycles.
  - First later edge with alu_done=1: num_reg = alu_number, ovf_reg = alu_overflow, go to RESP. rsp_data = alu_number.
  - No done by count DET_TIMEOUT: rsp_err=1, num_reg/ovf_reg unchanged, go to RESP.
- RESP: alu_opcode = 000. rsp_valid=1 and rsp_* remain stable until rsp_valid & rsp_ready at an edge, then IDLE. The next instruction is accepted in the cycle after that handshake.
- Latency:
  - LOAD/CONFIG/READ: rsp_valid asserted the cycle after accept.
  - EXEC 001-110: rsp_valid asserted SETTLE_CYCLES+1 cycles after accept.
- Operand registers are never modified during EXEC. C_reg is updated only by a successful capture.
- rsp_err responses for EXEC leave the previous results intact.

Test Plan:
- LOAD A[0]=0xE4, A[24]=0x01, then READ sel0 before any EXEC -> rsp_data 0x00. Inspect alu_a_flat -> [7:0]=E4, [199:192]=01.
- LOAD A all 0x01, B all 0x02, EXEC 001 (ALU model) -> rsp after 2 cycles, err=0. READ C[12] -> 0x03.
- CONFIG size=2; load A=[1 2;3 4] at indices 0,1,5,6; EXEC 111; ALU model raises done after 5 cycles -> rsp_data 0xFE (-2). READ sel1 -> 0xFE.
- Error cases:
  - LOAD index 25 -> rsp_err=1, A unchanged.
  - CONFIG size 6 -> err, alu_matrix_size stays 5.
  - EXEC 000 -> err.
- EXEC 111 with alu_done held 0 -> rsp_err=1 exactly DET_TIMEOUT cycles after accept; alu_opcode returns to 000.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp stable and instr_ready=0 throughout. Assert reset_n=0 mid-EXEC -> all outputs reach reset values immediately and no response follows.
